// File: rtl/abc_seq_ctrl.sv
// abc_seq_ctrl: generates one three-cycle a/b/c pulse train per accepted
// request, followed by a programmable idle gap. MODE fixes the pulse order
// at elaboration: 0 gives a,b,c (antecedent), 1 gives c,a,b (consequent).
module abc_seq_ctrl #(
  parameter int MODE  = 0,
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [GAP_W-1:0] req_gap,
  output logic             req_ready,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Only the two orderings are meaningful; anything else stops elaboration.
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("abc_seq_ctrl: MODE must be 0 or 1");
  end

  // Pulse pattern {a,b,c} driven in each train state for the chosen order.
  localparam logic [2:0] PULSE1 = (MODE == 1) ? 3'b001 : 3'b100;
  localparam logic [2:0] PULSE2 = (MODE == 1) ? 3'b100 : 3'b010;
  localparam logic [2:0] PULSE3 = (MODE == 1) ? 3'b010 : 3'b001;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;

  // Handshake and activity flags are pure decodes of the registered state.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer: state, gap counter, completion counter and registered pulses.
  // Pulse outputs are loaded alongside the state they belong to, so they
  // appear in the same cycle the state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      seq_count <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      done      <= 1'b0;
    end else begin
      a    <= 1'b0;
      b    <= 1'b0;
      c    <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !abort) begin
            state       <= P1;
            gap_cnt     <= req_gap;
            {a, b, c}   <= PULSE1;
          end
        end
        P1: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state     <= P2;
            {a, b, c} <= PULSE2;
          end
        end
        P2: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state     <= P3;
            {a, b, c} <= PULSE3;
            done      <= 1'b1;
          end
        end
        P3: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            seq_count <= seq_count + CNT_W'(1);
            if (gap_cnt != '0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abc_seq_ctrl.sv
// tb_abc_seq_ctrl: drives an antecedent instance (2-bit counter) and a
// consequent instance (8-bit counter) with identical stimulus and compares
// both against a phase-based reference model, plus explicit vector tables.
module tb_abc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] req_gap = 4'd0;

  logic       ready0, a0, b0, c0, busy0, done0;
  logic [1:0] cnt0;
  logic       ready1, a1, b1, c1, busy1, done1;
  logic [7:0] cnt1;

  int checks = 0;
  int errors = 0;

  // Model state per instance: phase 0 = idle, 1..3 = pulse k, 4.. = gap.
  int phase [2];
  int gap_len [2];
  int trains [2];

  logic [2:0] prev_abc0;
  logic       prev_valid;

  typedef struct {
    logic       rv;
    logic [3:0] gap;
    logic       ab;
    logic [2:0] abc;
    logic       done;
    logic       ready;
    logic       busy;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs [19];

  // Free-running clock.
  always #5 clk = ~clk;

  abc_seq_ctrl #(.MODE(0), .GAP_W(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gap(req_gap),
    .req_ready(ready0), .abort(abort), .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .seq_count(cnt0)
  );

  abc_seq_ctrl #(.MODE(1), .GAP_W(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gap(req_gap),
    .req_ready(ready1), .abort(abort), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .seq_count(cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Pulse expected in pulse phase k: letter index (a=0,b=1,c=2) rotates by mode.
  function automatic logic [2:0] modelAbc(input int inst);
    if (phase[inst] >= 1 && phase[inst] <= 3)
      return 3'b100 >> ((phase[inst] - 1 + 2 * inst) % 3);
    return 3'b000;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      phase[i]   = 0;
      gap_len[i] = 0;
      trains[i]  = 0;
    end
    prev_valid = 1'b0;
  endtask

  task automatic modelEdge(input logic rv, input logic [3:0] gp, input logic ab);
    for (int i = 0; i < 2; i++) begin
      if (phase[i] == 0) begin
        if (rv && !ab) begin
          phase[i]   = 1;
          gap_len[i] = int'(gp);
        end
      end else if (ab) begin
        phase[i] = 0;
      end else if (phase[i] == 3) begin
        trains[i]++;
        phase[i] = (gap_len[i] == 0) ? 0 : 4;
      end else if (phase[i] >= 4 && phase[i] - 3 == gap_len[i]) begin
        phase[i] = 0;
      end else begin
        phase[i]++;
      end
    end
  endtask

  task automatic compareModel(input logic ab);
    logic [2:0] abc0;
    abc0 = {a0, b0, c0};
    checkOutput("abc0",   abc0,   modelAbc(0));
    checkOutput("done0",  done0,  phase[0] == 3);
    checkOutput("ready0", ready0, phase[0] == 0);
    checkOutput("busy0",  busy0,  phase[0] != 0);
    checkOutput("cnt0",   cnt0,   trains[0] % 4);
    checkOutput("abc1",   {a1, b1, c1}, modelAbc(1));
    checkOutput("done1",  done1,  phase[1] == 3);
    checkOutput("ready1", ready1, phase[1] == 0);
    checkOutput("busy1",  busy1,  phase[1] != 0);
    checkOutput("cnt1",   cnt1,   trains[1] % 256);
    if (prev_valid) begin
      if (b0) checkOutput("prop_b_after_a", prev_abc0[2], 1'b1);
      if (c0) checkOutput("prop_c_after_b", prev_abc0[1], 1'b1);
      if (prev_abc0[2] && !ab) checkOutput("prop_a_then_b", b0, 1'b1);
      if (prev_abc0[1] && !ab) checkOutput("prop_b_then_c", c0, 1'b1);
    end
    prev_abc0  = abc0;
    prev_valid = 1'b1;
  endtask

  // Inputs change on the falling edge; outputs are compared on the next one.
  task automatic applyStimulus(input logic rv, input logic [3:0] gp, input logic ab);
    req_valid = rv;
    req_gap   = gp;
    abort     = ab;
    @(posedge clk);
    modelEdge(rv, gp, ab);
    @(negedge clk);
    compareModel(ab);
  endtask

  initial begin
    int pulses_a;
    int gap_cycles;
    logic seen_ready;

    vecs[0]  = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, 4'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[5]  = '{1'b1, 4'd2, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 4'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 4'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[13] = '{1'b0, 4'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[14] = '{1'b0, 4'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[15] = '{1'b1, 4'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[16] = '{1'b0, 4'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[17] = '{1'b0, 4'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[18] = '{1'b0, 4'd0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2};

    // Asynchronous reset, checked before any clock edge.
    modelReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_abc0",   {a0, b0, c0}, 3'b000);
    checkOutput("reset_ready0", ready0, 1'b1);
    checkOutput("reset_busy0",  busy0, 1'b0);
    checkOutput("reset_done0",  done0, 1'b0);
    checkOutput("reset_cnt0",   cnt0, 2'd0);
    checkOutput("reset_cnt1",   cnt1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Explicit vectors: single trains, gap of 2, abort in IDLE/P2/P3.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].gap, vecs[i].ab);
      checkOutput($sformatf("vec%0d_abc", i),   {a0, b0, c0}, vecs[i].abc);
      checkOutput($sformatf("vec%0d_done", i),  done0,  vecs[i].done);
      checkOutput($sformatf("vec%0d_ready", i), ready0, vecs[i].ready);
      checkOutput($sformatf("vec%0d_busy", i),  busy0,  vecs[i].busy);
      checkOutput($sformatf("vec%0d_cnt", i),   cnt0,   vecs[i].cnt);
    end

    // Back-to-back trains with req_valid held: five trains in 20 cycles,
    // counter 2 -> 3,0,1,2,3 wraps through zero.
    pulses_a = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0);
      if (a0) pulses_a++;
    end
    checkOutput("b2b_trains", pulses_a, 5);
    checkOutput("b2b_cnt_wrap", cnt0, 2'd3);
    applyStimulus(1'b0, 4'd0, 1'b0);

    // Reset dropped between edges while in P2.
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("pre_reset_b0", b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_abc0",  {a0, b0, c0}, 3'b000);
    checkOutput("midrst_abc1",  {a1, b1, c1}, 3'b000);
    checkOutput("midrst_ready", ready0, 1'b1);
    checkOutput("midrst_busy",  busy0, 1'b0);
    checkOutput("midrst_cnt0",  cnt0, 2'd0);
    checkOutput("midrst_cnt1",  cnt1, 8'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("post_reset_cnt0", cnt0, 2'd1);

    // Maximum gap with req_valid held: 15 quiet busy cycles, then IDLE.
    applyStimulus(1'b1, 4'd15, 1'b0);
    gap_cycles = 0;
    seen_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0);
      if (busy0 && !a0 && !b0 && !c0) gap_cycles++;
      if (ready0) begin
        seen_ready = 1'b1;
        break;
      end
    end
    checkOutput("maxgap_cycles", gap_cycles, 15);
    checkOutput("maxgap_ready_seen", seen_ready, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       rv;
      logic [3:0] gp;
      logic       ab;
      rv = ($urandom_range(0, 9) < 7);
      gp = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      ab = ($urandom_range(0, 19) == 0);
      applyStimulus(rv, gp, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
